nios_imageline_bridge: RTL
==========================

# nios_imageline_bridge

Parametrised Avalon-MM slave linking the Nios II data bus to the imageline/LCD-camera datapath. It replaces the fixed single-word SDRAM interface with three additions: a buffered SDRAM write path, a valid-qualified SDRAM read path, and a generic bank of filter-configuration registers. It sits between the Nios system interconnect and the SDRAM controller and filter pipeline.

## Interface
- DATA_W, 16: width of each SDRAM data lane; bus word is {lane1, lane2}, 2*DATA_W ≤ 32.
- NUM_CFG, 4: number of filter-config registers, 1..16.
- FIFO_DEPTH, 8: write-FIFO entries, power of 2, ≥ 2.
- ADDR_W, 11: Avalon word-address width.
- Clock  in  1  system clock.
- Resetn  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  word address.
- chipselect, read, write  in  1 each  Avalon strobes; read and write are never asserted together.
- writedata  in  32  write data.
- readdata  out  32  read data.
- waitrequest  out  1  stall.
- SDRAM_wren  out  1  one-cycle write strobe.
- SDRAM_wr_ready  in  1  SDRAM accepts a write this cycle.
- SDRAM_wr_data_1, SDRAM_wr_data_2  out  DATA_W each  write lanes.
- SDRAM_rden  out  1  one-cycle read strobe.
- SDRAM_rd_valid  in  1  read data valid.
- SDRAM_rd_data_1, SDRAM_rd_data_2  in  DATA_W each  read lanes.
- SDRAM_wr_src, SDRAM_rd_src  out  1 each  source selects.
- State_reload  out  3  state reload value.
- State_read  in  3  current state.
- Filter_config  out  NUM_CFG×32  config bank, flattened; register k is at bits [32k+31:32k].

## Operation
- Address map:
  - 0: data port.
  - 1: control/status.
  - 2: FIFO control.
  - 4..4+NUM_CFG-1: config registers.
  - Other addresses: writes are ignored; reads return 0.
- Write to 0: pushes {writedata[2*DATA_W-1:DATA_W], writedata[DATA_W-1:0]} into the write FIFO.
- FIFO drain: when the FIFO is non-empty and SDRAM_wr_ready=1, pop the head, pulse SDRAM_wren, and present the head on the lanes that cycle.
- Write to 1:
  - State_reload ← writedata[4:2].
  - SDRAM_wr_src ← writedata[1].
  - SDRAM_rd_src ← writedata[0].
  - Takes effect immediately, without waiting for the FIFO to drain. Software polls the empty bit before switching sources.
- Read 1 returns:
  - [31:16] = FIFO level.
  - [7] = sticky overflow.
  - [6] = FIFO empty.
  - [5] = FIFO full.
  - [4:2] = State_read.
  - [1] = SDRAM_wr_src.
  - [0] = SDRAM_rd_src.
- Write to 2: writedata[0]=1 flushes the FIFO; writedata[1]=1 clears the overflow flag.
- Read 2 returns the same word as read 1.
- Write to 4+k: Filter_config register k ← writedata.
- Read 0: pulses SDRAM_rden once, waits for SDRAM_rd_valid, then returns {SDRAM_rd_data_1, SDRAM_rd_data_2} zero-extended.
- No ordering is enforced between the write FIFO and data-port reads.
- Read FSM states: IDLE → ISSUE (SDRAM_rden=1, one cycle) → WAIT (until SDRAM_rd_valid) → DONE (ack) → IDLE.

## Timing
- Reset: every output and register is 0, the FIFO is empty, overflow is 0, and the FSM is in IDLE.
- waitrequest = chipselect & ~ack, combinational; ack is a registered single-cycle pulse.
- Register access (addresses 1, 2, 4+):
  - chipselect rises in cycle 0; ack=1 and readdata are valid in cycle 1.
  - The write side effect lands at the edge ending cycle 0.
  - Latency is exactly one wait state.
- Data-port write:
  - Ack the cycle after FIFO not-full is seen; the push happens on the ack edge.
  - While the FIFO is full, waitrequest stays high.
  - A push into a full FIFO is never performed. A simultaneous pop does not admit a push in the same cycle.
- Data-port read:
  - SDRAM_rden rises one cycle after the request.
  - readdata is captured on the SDRAM_rd_valid edge; ack follows one cycle later.
  - Minimum latency is 3 cycles.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits wide; they wrap modulo 2·FIFO_DEPTH.
- Overflow flag: set only via the FIFO's overflow-indication input, and never set by a blocked bus write.
- Flush: clears the pointers at the edge ending the flush write. Any pop in that same cycle is suppressed, so SDRAM_wren=0.
- Asynchronous reset mid-transaction returns to the reset state. A pending bus transaction is not acked; the master's reset covers it.
- chipselect dropped mid-read: the FSM completes to IDLE, discards the data, and issues no ack.

## Configuration
- Macro: IMAGELINE_CFG_READBACK_EN.
  - Defined: reads of 4+k return Filter_config register k.
  - Undefined: those reads return 0 and the readback mux is not built.

## Structure
- Package imageline_pkg holds:
  - Address constants ADDR_DATA=0, ADDR_CTRL=1, ADDR_FIFO=2, ADDR_CFG_BASE=4.
  - Status bit-position constants.
  - The read-FSM state enum (IDLE, ISSUE, WAIT, DONE).
- Sub-module imageline_wr_fifo, parameterised by width 2*DATA_W and depth FIFO_DEPTH, with:
  - push/pop/flush inputs;
  - full/empty/level outputs;
  - an overflow-indication input.

## Test plan
- Reset, then read address 1 → 0x0000_0040 (empty=1); all outputs 0.
- Hold SDRAM_wr_ready=0 and write 9 words to address 0 with FIFO_DEPTH=8:
  - the 9th write stalls with waitrequest high;
  - status level = 8 and full=1.
  - Then raise SDRAM_wr_ready: 9 SDRAM_wren pulses drain the data in order; the 9th write completes.
- Write 0xDEAD_BEEF to address 0 with SDRAM_wr_ready=1 → one SDRAM_wren with lane1=0xDEAD, lane2=0xBEEF.
- Read address 0, with SDRAM_rd_valid returned 4 cycles after SDRAM_rden and data 0x1234/0x5678 → readdata=0x1234_5678, SDRAM_rden high exactly 1 cycle, total latency 6 cycles.
- Write 0x1D to address 1 → State_reload=7, wr_src=0, rd_src=1. Write 0xA5A5_0001 to address 5 → Filter_config[63:32]=0xA5A5_0001. Read address 5 → 0xA5A5_0001 with the macro defined, 0 without it.
- Fill 3 entries (SDRAM_wr_ready=0), then write 1 to address 2 → level=0 and empty=1; no SDRAM_wren occurs afterward.

Source files
------------

// File: rtl/imageline_pkg.sv
// Shared constants for the Nios imageline bridge: register map, status word
// bit positions and the data-port read FSM states.
package imageline_pkg;

    localparam int ADDR_DATA     = 0;
    localparam int ADDR_CTRL     = 1;
    localparam int ADDR_FIFO     = 2;
    localparam int ADDR_CFG_BASE = 4;

    localparam int ST_LEVEL_LSB = 16;
    localparam int ST_OVF       = 7;
    localparam int ST_EMPTY     = 6;
    localparam int ST_FULL      = 5;
    localparam int ST_STATE_LSB = 2;
    localparam int ST_WR_SRC    = 1;
    localparam int ST_RD_SRC    = 0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} rd_state_e;

endpackage

// File: rtl/imageline_wr_fifo.sv
// Write-side buffer between the Avalon data port and the SDRAM write lanes.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module imageline_wr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     ovf_in,
    input  logic                     ovf_clr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     popped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    assign level    = wptr_q - rptr_q;
    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // Full is judged on the registered pointers, so a pop never frees a slot
    // for a push in the same cycle.
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty & ~flush;
    assign popped   = do_pop;
    assign rdata    = mem_q[rptr_q[AW-1:0]];
    assign overflow = ovf_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        ovf_d  = ovf_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q[AW-1:0]] = wdata;
                wptr_d = wptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rptr_d = rptr_q + PTR_ONE;
            end
        end
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_in)  ovf_d = 1'b1;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/nios_imageline_bridge.sv
// Avalon-MM slave joining the Nios data bus to the SDRAM and filter pipeline.
// Build with IMAGELINE_CFG_READBACK_EN defined to make config registers readable.
module nios_imageline_bridge
    import imageline_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_CFG    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 11
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  waitrequest,
    output logic                  SDRAM_wren,
    input  logic                  SDRAM_wr_ready,
    output logic [DATA_W-1:0]     SDRAM_wr_data_1,
    output logic [DATA_W-1:0]     SDRAM_wr_data_2,
    output logic                  SDRAM_rden,
    input  logic                  SDRAM_rd_valid,
    input  logic [DATA_W-1:0]     SDRAM_rd_data_1,
    input  logic [DATA_W-1:0]     SDRAM_rd_data_2,
    output logic                  SDRAM_wr_src,
    output logic                  SDRAM_rd_src,
    output logic [2:0]            State_reload,
    input  logic [2:0]            State_read,
    output logic [NUM_CFG*32-1:0] Filter_config,
    output logic [1:0]            dbg_rd_state
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_e            state_q, state_d;
    logic                 rden_q, rden_d, ack_q, ack_d, abandon_q, abandon_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [2:0]           reload_q, reload_d;
    logic                 wr_src_q, wr_src_d, rd_src_q, rd_src_d;
    logic [NUM_CFG*32-1:0] cfg_q, cfg_d;

    logic                 req, is_data, is_ctrl, is_fifo, is_cfg;
    logic [ADDR_W-1:0]    cfg_off;
    logic                 fifo_push, fifo_flush, fifo_ovf_clr, fifo_full, fifo_empty;
    logic                 fifo_ovf, fifo_popped;
    logic [2*DATA_W-1:0]  fifo_head;
    logic [LVL_W-1:0]     fifo_level;
    logic [31:0]          status, cfg_rd;

    imageline_wr_fifo #(.WIDTH(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .push     (fifo_push),
        .pop      (SDRAM_wr_ready),
        .flush    (fifo_flush),
        // Bus pushes wait for space, so this bridge itself never overruns.
        .ovf_in   (1'b0),
        .ovf_clr  (fifo_ovf_clr),
        .wdata    (writedata[2*DATA_W-1:0]),
        .rdata    (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .overflow (fifo_ovf),
        .popped   (fifo_popped)
    );

    // Handshake: waitrequest is high for every cycle of a selected access
    // except the single registered ack cycle; a new request is only taken
    // while the read FSM is idle and no ack is being presented.
    assign waitrequest = chipselect & ~ack_q;
    assign req         = chipselect & ~ack_q & (state_q == IDLE);

    assign is_data = (address == ADDR_W'(ADDR_DATA));
    assign is_ctrl = (address == ADDR_W'(ADDR_CTRL));
    assign is_fifo = (address == ADDR_W'(ADDR_FIFO));
    assign is_cfg  = (address >= ADDR_W'(ADDR_CFG_BASE)) &&
                     (address <  ADDR_W'(ADDR_CFG_BASE + NUM_CFG));
    assign cfg_off = address - ADDR_W'(ADDR_CFG_BASE);

    always_comb begin
        status = '0;
        status[ST_LEVEL_LSB +: LVL_W] = fifo_level;
        status[ST_OVF]                = fifo_ovf;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_FULL]               = fifo_full;
        status[ST_STATE_LSB +: 3]     = State_read;
        status[ST_WR_SRC]             = wr_src_q;
        status[ST_RD_SRC]             = rd_src_q;
    end

`ifdef IMAGELINE_CFG_READBACK_EN
    always_comb begin
        cfg_rd = '0;
        for (int k = 0; k < NUM_CFG; k++) begin
            if (cfg_off == ADDR_W'(k)) cfg_rd = cfg_q[k*32 +: 32];
        end
    end
`else
    assign cfg_rd = '0;
`endif

    always_comb begin
        state_d      = state_q;
        rden_d       = 1'b0;
        ack_d        = 1'b0;
        abandon_d    = abandon_q;
        rdata_d      = rdata_q;
        reload_d     = reload_q;
        wr_src_d     = wr_src_q;
        rd_src_d     = rd_src_q;
        cfg_d        = cfg_q;
        fifo_push    = 1'b0;
        fifo_flush   = 1'b0;
        fifo_ovf_clr = 1'b0;

        // A read whose chipselect drops still runs to IDLE but is never acked.
        case (state_q)
            IDLE: begin
                abandon_d = 1'b0;
                if (req && read && is_data) begin
                    state_d = ISSUE;
                    rden_d  = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                if (!chipselect) abandon_d = 1'b1;
            end
            WAIT: begin
                if (!chipselect) abandon_d = 1'b1;
                if (SDRAM_rd_valid) begin
                    state_d = DONE;
                    if (chipselect && !abandon_q) begin
                        ack_d   = 1'b1;
                        rdata_d = 32'({SDRAM_rd_data_1, SDRAM_rd_data_2});
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (req && write) begin
            if (is_data) begin
                fifo_push = ~fifo_full;
                ack_d     = ~fifo_full;
            end else begin
                ack_d = 1'b1;
                if (is_ctrl) begin
                    reload_d = writedata[4:2];
                    wr_src_d = writedata[1];
                    rd_src_d = writedata[0];
                end
                if (is_fifo) begin
                    fifo_flush   = writedata[0];
                    fifo_ovf_clr = writedata[1];
                end
                for (int k = 0; k < NUM_CFG; k++) begin
                    if (is_cfg && cfg_off == ADDR_W'(k)) cfg_d[k*32 +: 32] = writedata;
                end
            end
        end

        if (req && read && !is_data) begin
            ack_d = 1'b1;
            if (is_ctrl || is_fifo) rdata_d = status;
            else if (is_cfg)        rdata_d = cfg_rd;
            else                    rdata_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            rden_q    <= 1'b0;
            ack_q     <= 1'b0;
            abandon_q <= 1'b0;
            rdata_q   <= '0;
            reload_q  <= '0;
            wr_src_q  <= 1'b0;
            rd_src_q  <= 1'b0;
            cfg_q     <= '0;
        end else begin
            state_q   <= state_d;
            rden_q    <= rden_d;
            ack_q     <= ack_d;
            abandon_q <= abandon_d;
            rdata_q   <= rdata_d;
            reload_q  <= reload_d;
            wr_src_q  <= wr_src_d;
            rd_src_q  <= rd_src_d;
            cfg_q     <= cfg_d;
        end
    end

    assign readdata        = rdata_q;
    assign SDRAM_rden      = rden_q;
    assign SDRAM_wren      = fifo_popped;
    assign SDRAM_wr_data_1 = fifo_popped ? fifo_head[2*DATA_W-1:DATA_W] : '0;
    assign SDRAM_wr_data_2 = fifo_popped ? fifo_head[DATA_W-1:0] : '0;
    assign SDRAM_wr_src    = wr_src_q;
    assign SDRAM_rd_src    = rd_src_q;
    assign State_reload    = reload_q;
    assign Filter_config   = cfg_q;
    assign dbg_rd_state    = state_q;

endmodule
